// File: rtl/comb_share_pkg.sv
// Shared types and constants for the comb_share_arbiter slice.
// The optional grant lock is enabled with the COMB_SHARE_LOCK_EN macro.
package comb_share_pkg;

   typedef enum logic [1:0] {
      PASS1  = 2'd0,
      MINSEL = 2'd1,
      LSBDEC = 2'd2,
      PASS2  = 2'd3
   } op_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [2:0] LSBDEC_BASE = 3'd7;

endpackage

// File: rtl/comb_share_alu.sv
// Combinational compare/select/decode unit shared by all requesters.
module comb_share_alu
   import comb_share_pkg::*;
#(
   parameter int unsigned size = 8
) (
   input  op_e             op,
   input  logic [size-1:0] src1,
   input  logic [size-1:0] src2,
   input  logic [size-1:0] src3,
   output logic [size-1:0] result
);

   logic [2:0] dec;

   // Decode base minus the packed operand LSBs; resized to the datapath width.
   assign dec = LSBDEC_BASE - {src1[0], src2[0], src3[0]};

   always_comb begin
      result = '0;
      unique case (op)
         PASS1:   result = src1;
         MINSEL:  result = (src1 < src2) ? src1 : src3;
         LSBDEC:  result = size'(dec);
         PASS2:   result = src2;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/comb_share_arbiter.sv
// Round-robin arbiter sharing one comb_share_alu among NREQ requesters,
// with a single-entry tagged output register. Optional lock: COMB_SHARE_LOCK_EN.
module comb_share_arbiter
   import comb_share_pkg::*;
#(
   parameter  int unsigned size = 8,
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [size*NREQ-1:0] req_src1,
   input  logic [size*NREQ-1:0] req_src2,
   input  logic [size*NREQ-1:0] req_src3,
   input  logic [NREQ-1:0]      req_lock,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [size-1:0]      rsp_data
);

   state_e          state_q;
   logic [IDW-1:0]  last_grant_q;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [size-1:0] rsp_data_q;

   logic [1:0]      op_a   [NREQ];
   logic [size-1:0] src1_a [NREQ];
   logic [size-1:0] src2_a [NREQ];
   logic [size-1:0] src3_a [NREQ];

   logic [NREQ-1:0] lock_mask;
   logic [NREQ-1:0] elig;
   logic            win_found;
   logic [IDW-1:0]  win_idx;
   logic [IDW-1:0]  cand;
   logic            can_accept;
   logic            accept;
   logic [size-1:0] data_d;
   logic [IDW-1:0]  id_d;

   for (genvar k = 0; k < int'(NREQ); k++) begin : g_unpack
      assign op_a[k]   = req_op[2*k +: 2];
      assign src1_a[k] = req_src1[size*k +: size];
      assign src2_a[k] = req_src2[size*k +: size];
      assign src3_a[k] = req_src3[size*k +: size];
   end

`ifdef COMB_SHARE_LOCK_EN
   logic           lock_q;
   logic [IDW-1:0] lock_id_q;

   // While locked only the owner is eligible, even when it is idle.
   always_comb begin
      lock_mask = '1;
      if (lock_q) begin
         lock_mask            = '0;
         lock_mask[lock_id_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else if (accept) begin
         lock_q    <= req_lock[win_idx];
         lock_id_q <= win_idx;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign lock_mask   = '1;
`endif

   assign elig = req_valid & lock_mask;

   // Round-robin search starting one past the last accepted requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IDW'((32'(last_grant_q) + i) % NREQ);
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign can_accept = (state_q == EMPTY) || rsp_ready;
   assign accept     = win_found && can_accept;
   assign id_d       = win_idx;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_idx] = 1'b1;
   end

   comb_share_alu #(.size(size)) u_alu (
      .op     (op_e'(op_a[win_idx])),
      .src1   (src1_a[win_idx]),
      .src2   (src2_a[win_idx]),
      .src3   (src3_a[win_idx]),
      .result (data_d)
   );

   // Output-stage FSM; a held result stays put until drained or replaced.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         last_grant_q <= IDW'(NREQ - 1);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
      end else begin
         if (accept) begin
            last_grant_q <= win_idx;
            rsp_id_q     <= id_d;
            rsp_data_q   <= data_d;
         end
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= FULL;
                  rsp_valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (!accept && rsp_ready) begin
                  state_q     <= EMPTY;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= EMPTY;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule
